// File: rtl/gate_id_pkg.sv
// gate_id_pkg: definitions shared by the gate identifier.
// Contents:
//   state_t      - controller states (IDLE, DRIVE, DECODE)
//   TT_*         - 4-bit truth tables, bit index = {sw1,sw0}
//   CODE_*       - 3-bit function select codes
package gate_id_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        DECODE = 2'd2
    } state_t;

    localparam logic [3:0] TT_NOT  = 4'b0101;
    localparam logic [3:0] TT_BUF  = 4'b1010;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;

    localparam logic [2:0] CODE_NOT  = 3'd0;
    localparam logic [2:0] CODE_BUF  = 3'd1;
    localparam logic [2:0] CODE_XNOR = 3'd2;
    localparam logic [2:0] CODE_XOR  = 3'd3;
    localparam logic [2:0] CODE_OR   = 3'd4;
    localparam logic [2:0] CODE_NOR  = 3'd5;
    localparam logic [2:0] CODE_AND  = 3'd6;
    localparam logic [2:0] CODE_NAND = 3'd7;

endpackage

// File: rtl/tt_decode.sv
// tt_decode: combinational truth-table to function-code lookup.
// Ports:
//   tt[3:0]    in  - observed truth table, bit index = {sw1,sw0}
//   code[2:0]  out - matching function code (000 when no match)
//   code_valid out - 1 when tt matches one of the eight functions
module tt_decode
    import gate_id_pkg::*;
(
    input  logic [3:0] tt,
    output logic [2:0] code,
    output logic       code_valid
);

    always_comb begin
        code       = '0;
        code_valid = 1'b1;
        case (tt)
            TT_NOT:  code = CODE_NOT;
            TT_BUF:  code = CODE_BUF;
            TT_XNOR: code = CODE_XNOR;
            TT_XOR:  code = CODE_XOR;
            TT_OR:   code = CODE_OR;
            TT_NOR:  code = CODE_NOR;
            TT_AND:  code = CODE_AND;
            TT_NAND: code = CODE_NAND;
            default: begin
                code       = '0;
                code_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/gate_identifier.sv
// gate_identifier: drives the four input patterns into a 2-input gate under
// test, records its response and identifies the gate function.
// Parameter:
//   SETTLE       - wait cycles per pattern before sampling (0..15)
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - begin a run (accepted only when idle)
//   probe_in     - output of the gate under test
//   probe_sw0/1  - stimulus to the gate under test
//   busy         - run in progress
//   done         - one-cycle completion pulse
//   code         - identified function code
//   code_valid   - observed table matched a known function
// Build option:
//   GATE_ID_SYNC_EN - two-flop synchronizer on probe_in, settle >= 2
module gate_identifier
    import gate_id_pkg::*;
#(
    parameter int SETTLE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       probe_in,
    output logic       probe_sw0,
    output logic       probe_sw1,
    output logic       busy,
    output logic       done,
    output logic [2:0] code,
    output logic       code_valid
);

    logic probe_s;

`ifdef GATE_ID_SYNC_EN
    // Two synchronizer stages need at least two settle cycles to flush.
    localparam int EFF_SETTLE = (SETTLE < 2) ? 2 : SETTLE;

    logic sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= probe_in;
            sync2 <= sync1;
        end
    end

    assign probe_s = sync2;
`else
    localparam int EFF_SETTLE = SETTLE;

    assign probe_s = probe_in;
`endif

    localparam logic [3:0] RELOAD = 4'(EFF_SETTLE);

    state_t     state;
    logic [1:0] pat;
    logic [3:0] cnt;
    logic [3:0] tt;
    logic [2:0] dec_code;
    logic       dec_valid;

    tt_decode u_tt_decode (
        .tt         (tt),
        .code       (dec_code),
        .code_valid (dec_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pat        <= '0;
            cnt        <= '0;
            tt         <= '0;
            probe_sw0  <= 1'b0;
            probe_sw1  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state                  <= DRIVE;
                        pat                    <= '0;
                        cnt                    <= RELOAD;
                        busy                   <= 1'b1;
                        {probe_sw1, probe_sw0} <= 2'b00;
                    end
                end
                DRIVE: begin
                    // Sample on the last hold cycle, then move to the next
                    // pattern; after pattern 3 the probes return to 00.
                    if (cnt == 4'd0) begin
                        tt[pat] <= probe_s;
                        if (pat == 2'd3) begin
                            state                  <= DECODE;
                            {probe_sw1, probe_sw0} <= 2'b00;
                        end else begin
                            pat                    <= pat + 2'd1;
                            cnt                    <= RELOAD;
                            {probe_sw1, probe_sw0} <= pat + 2'd1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DECODE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    code       <= dec_code;
                    code_valid <= dec_valid;
                    done       <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_identifier.md
GATE_IDENTIFIER -- requirements
Module: gate_identifier

Interface
REQ-001 SHALL have parameter SETTLE, default 3, the number of wait cycles after each probe pattern is driven, before probe_in is sampled; legal range 0..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin one identification run.
REQ-005 SHALL have port probe_in, input, 1 bit: the output of the gate under test.
REQ-006 SHALL have ports probe_sw0 and probe_sw1, each output, 1 bit: the stimulus driven to the gate under test.
REQ-007 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-009 SHALL have port code, output, 3 bits: the identified function select code.
REQ-010 SHALL have port code_valid, output, 1 bit: high when the observed truth table matches one of the 8 functions.

Function
REQ-011 SHALL use the code map 0=NOT sw0, 1=BUF sw0, 2=XNOR, 3=XOR, 4=OR, 5=NOR, 6=AND, 7=NAND.
REQ-012 SHALL use the truth tables tt[3:0] indexed by {sw1,sw0}: NOT=0101, BUF=1010, XNOR=1001, XOR=0110, OR=1110, NOR=0001, AND=1000, NAND=0111.
REQ-013 SHALL use the states IDLE, DRIVE, DECODE, with transitions IDLE->DRIVE on start, DRIVE->DECODE after pattern 3 is sampled, and DECODE->IDLE unconditionally.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-015 SHALL apply patterns {sw1,sw0} = 00, 01, 10, 11 in order during DRIVE, holding each pattern for SETTLE+1 cycles and sampling probe_in into tt[pattern] on the last of those cycles.
REQ-016 SHALL drive the probe outputs to 00 in IDLE and DECODE.
REQ-017 SHALL make busy a registered signal that is high from the cycle after start is accepted through the DECODE cycle inclusive.
REQ-018 SHALL perform the table lookup in DECODE and register code, code_valid and done on the DECODE->IDLE edge, giving done 4*(SETTLE+1)+1 cycles after the start edge.
REQ-019 SHALL, on no match (8 of the 16 tables), set code_valid=0 and code=3'b000.
REQ-020 SHALL hold code and code_valid stable until the next run's DECODE completes; a new start SHALL not clear them.
REQ-021 SHALL accept a start asserted in the same cycle that done is high, beginning a new run.
REQ-022 SHALL keep the settle counter 4 bits wide, reloading it to SETTLE on every pattern change with no wrap beyond 0.

Reset
REQ-023 SHALL, while rst is high, force state=IDLE, probe_sw0=probe_sw1=0, busy=0, done=0, code=000, code_valid=0 and tt=0000 immediately, independent of clk.
REQ-024 SHALL, when rst asserts mid-run, abort the run with no done pulse; the first start after rst deasserts SHALL begin a fresh run at pattern 00.

Configuration
REQ-025 SHALL, when GATE_ID_SYNC_EN is defined, pass probe_in through a two-flop synchronizer (reset to 0) before sampling; the effective settle SHALL be max(SETTLE,2), and the latency becomes 4*(max(SETTLE,2)+1)+1 cycles.
REQ-026 SHALL, when GATE_ID_SYNC_EN is undefined, sample probe_in directly, with timing per REQ-018.

Structure
REQ-027 SHALL place the state enum, the eight 4-bit truth-table constants and the eight 3-bit code constants in shared package gate_id_pkg.
REQ-028 SHALL implement the lookup as combinational sub-module tt_decode, with tt[3:0] in and code[2:0] plus code_valid out.

Verification
REQ-029 SHALL cover: SETTLE=3, DUT=AND, pulse start -> probe pattern sequence 00, 01, 10, 11, each held 4 cycles; done at cycle 17; code=6, code_valid=1.
REQ-030 SHALL cover: sweep all 8 functions back to back, restarting on each done cycle -> codes 0..7 in order, all with code_valid=1, no idle gap.
REQ-031 SHALL cover: DUT stuck at 1 (tt=1111) -> code=0, code_valid=0, done pulses once.
REQ-032 SHALL cover: start pulsed again 5 cycles into a run -> ignored; exactly one done at cycle 17.
REQ-033 SHALL cover: rst asserted at cycle 9 of a run, released, then start with DUT=XOR -> no done before the restart; code=3 at 17 cycles after the restart.
REQ-034 SHALL cover: GATE_ID_SYNC_EN defined, SETTLE=0, DUT=NOR -> done at cycle 13, code=5, code_valid=1.
